// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: mode encoding and direction constants.
package jk_pkg;

   typedef enum logic [1:0] {
      MODE_JK    = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_COUNT = 2'b10,
      MODE_SHIFT = 2'b11
   } mode_e;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous reset to a supplied value and a clock enable.
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic i_rst_val,
   input  logic i_en,
   input  logic i_j,
   input  logic i_k,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= i_rst_val;
      end else if (i_en) begin
         case ({i_j, i_k})
            2'b01:   r_q <= 1'b0;
            2'b10:   r_q <= 1'b1;
            2'b11:   r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of JK cells acting as independent JK bits, a parallel-load register,
// an up/down counter or a shift register, selected by mode.
module jk_reg_bank
   import jk_pkg::*;
#(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   input  logic             dir,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             sout
);

   mode_e            w_mode;
   logic [WIDTH-1:0] w_up_t;
   logic [WIDTH-1:0] w_dn_t;
   logic [WIDTH-1:0] w_t;
   logic [WIDTH-1:0] w_nb;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic             w_wrap;
   logic             r_tc;

   assign w_mode = mode_e'(mode);

   // Toggle enables: a bit flips when every lower bit is at its extreme.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_toggle
         if (gi == 0) begin : g_lsb
            assign w_up_t[gi] = 1'b1;
            assign w_dn_t[gi] = 1'b1;
         end else begin : g_upper
            assign w_up_t[gi] = &q[gi-1:0];
            assign w_dn_t[gi] = &(~q[gi-1:0]);
         end
      end
   endgenerate

   assign w_t  = (dir == DIR_UP)   ? w_up_t : w_dn_t;
   assign w_nb = (dir == DIR_LEFT) ? {q[WIDTH-2:0], sin} : {sin, q[WIDTH-1:1]};

   always_comb begin
      w_j = j;
      w_k = k;
      case (w_mode)
         MODE_LOAD: begin
            w_j = d;
            w_k = ~d;
         end
         MODE_COUNT: begin
            w_j = w_t;
            w_k = w_t;
         end
         MODE_SHIFT: begin
            w_j = w_nb;
            w_k = ~w_nb;
         end
         default: begin
            w_j = j;
            w_k = k;
         end
      endcase
   end

   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         jk_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .i_rst_val (RST_VAL[gi]),
            .i_en      (en),
            .i_j       (w_j[gi]),
            .i_k       (w_k[gi]),
            .o_q       (q[gi])
         );
      end
   endgenerate

   // The edge that wraps is the one leaving all-ones (up) or zero (down).
   assign w_wrap = (dir == DIR_UP) ? (&q) : ~(|q);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tc <= 1'b0;
      end else begin
         r_tc <= en && (w_mode == MODE_COUNT) && w_wrap;
      end
   end

   assign tc   = r_tc;
   assign sout = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed and randomized check of jk_reg_bank against a behavioural model.
module tb_jk_reg_bank;
   import jk_pkg::*;

   localparam int         W  = 8;
   localparam logic [7:0] RV = 8'hA5;

   logic       clk = 1'b0;
   logic       rst, en, dir, sin;
   logic [1:0] mode;
   logic [7:0] j, k, d, q;
   logic       tc, sout;

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   logic [7:0] m_q;
   logic       m_tc;

   jk_reg_bank #(.WIDTH(W), .RST_VAL(RV)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .j    (j),
      .k    (k),
      .d    (d),
      .dir  (dir),
      .sin  (sin),
      .q    (q),
      .tc   (tc),
      .sout (sout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: arithmetic counting, explicit set/clear/toggle table per bit.
   task automatic model_step();
      logic [7:0] n;
      n = m_q;
      if (rst) begin
         n    = RV;
         m_tc = 1'b0;
      end else if (!en) begin
         m_tc = 1'b0;
      end else begin
         m_tc = 1'b0;
         case (mode)
            2'd0: for (int b = 0; b < W; b++) begin
               if (j[b] && k[b])      n[b] = ~m_q[b];
               else if (j[b])         n[b] = 1'b1;
               else if (k[b])         n[b] = 1'b0;
            end
            2'd1: n = d;
            2'd2: begin
               if (dir) begin
                  n    = m_q + 8'd1;
                  m_tc = (m_q == 8'hFF);
               end else begin
                  n    = m_q - 8'd1;
                  m_tc = (m_q == 8'h00);
               end
            end
            default: n = dir ? ((m_q << 1) | {7'd0, sin}) : ((m_q >> 1) | {sin, 7'd0});
         endcase
      end
      m_q = n;
   endtask

   task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd,
                      input logic dr, input logic s);
      rst = r; en = e; mode = m; j = jj; k = kk; d = dd; dir = dr; sin = s;
      model_step();
      @(posedge clk);
      #1;
      txn++;
      $display("txn %0d rst=%b en=%b mode=%0d dir=%b q=%h tc=%b sout=%b", txn, r, e, m, dr, q, tc, sout);
      chk("q", 32'(q), 32'(m_q));
      chk("tc", 32'(tc), 32'(m_tc));
      chk("sout", 32'(sout), 32'(dir ? m_q[7] : m_q[0]));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 2'd0; j = '0; k = '0; d = '0; dir = 1'b0; sin = 1'b0;
      m_q = RV; m_tc = 1'b0;

      // Reset outranks enable and LOAD
      cyc(1, 1, MODE_LOAD, 8'h00, 8'h00, 8'hFF, 0, 0);
      chk("rst_q", 32'(q), 32'h A5);
      chk("rst_tc", 32'(tc), 32'h0);

      // JK set/clear/toggle
      cyc(0, 1, MODE_LOAD, 8'h00, 8'h00, 8'h0F, 0, 0);
      cyc(0, 1, MODE_JK, 8'hF0, 8'h3C, 8'h00, 0, 0);
      chk("jk1", 32'(q), 32'hF3);
      cyc(0, 1, MODE_JK, 8'hFF, 8'hFF, 8'h00, 0, 0);
      chk("jk2", 32'(q), 32'h0C);

      // Count up through the wrap
      cyc(0, 1, MODE_LOAD, 8'h00, 8'h00, 8'hFD, 1, 0);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 1, 0);
      chk("up_fe", 32'(q), 32'hFE);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 1, 0);
      chk("up_ff_tc", 32'(tc), 32'h0);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 1, 0);
      chk("up_00", 32'(q), 32'h00);
      chk("up_tc", 32'(tc), 32'h1);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 1, 0);
      chk("up_01_tc", 32'(tc), 32'h0);

      // Count down through the wrap, then pause and resume
      cyc(0, 1, MODE_LOAD, 8'h00, 8'h00, 8'h01, 0, 0);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 0, 0);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 0, 0);
      chk("dn_ff", 32'(q), 32'hFF);
      chk("dn_tc", 32'(tc), 32'h1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, MODE_COUNT, 8'h00, 8'h00, 8'h00, 0, 0);
         chk("pause_tc", 32'(tc), 32'h0);
      end
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 0, 0);
      chk("resume", 32'(q), 32'hFE);

      // Shift left then right
      cyc(0, 1, MODE_LOAD, 8'h00, 8'h00, 8'h81, 1, 0);
      cyc(0, 1, MODE_SHIFT, 8'h00, 8'h00, 8'h00, 1, 0);
      chk("shl", 32'(q), 32'h02);
      chk("shl_sout", 32'(sout), 32'h0);
      cyc(0, 1, MODE_SHIFT, 8'h00, 8'h00, 8'h00, 0, 1);
      chk("shr", 32'(q), 32'h81);
      chk("shr_sout", 32'(sout), 32'h1);

      // Reset on the edge that would wrap, then resume from RST_VAL
      cyc(0, 1, MODE_LOAD, 8'h00, 8'h00, 8'hFE, 1, 0);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 1, 0);
      cyc(1, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 1, 0);
      chk("midrst_q", 32'(q), 32'hA5);
      chk("midrst_tc", 32'(tc), 32'h0);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 1, 0);
      chk("post_rst", 32'(q), 32'hA6);

      // Direction reversal at zero
      cyc(0, 1, MODE_LOAD, 8'h00, 8'h00, 8'h00, 1, 0);
      cyc(0, 1, MODE_COUNT, 8'h00, 8'h00, 8'h00, 0, 0);
      chk("rev_q", 32'(q), 32'hFF);
      chk("rev_tc", 32'(tc), 32'h1);

      // Randomized traffic, biased toward long COUNT runs to hit wraps
      for (int i = 0; i < 600; i++) begin
         logic [1:0] rm;
         rm = (i % 150 < 60) ? 2'd2 : 2'($urandom_range(0, 3));
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0), rm,
             8'($urandom), 8'($urandom), 8'($urandom),
             (i % 150 < 60) ? ((i / 150) % 2 == 0) : 1'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised bank of WIDTH JK flip-flops with a shared mode control. Each bit can run as an independent JK cell, or the bank can act as a parallel-load register, an up/down synchronous counter or a shift register. All four modes are built from the same JK cell. The block is the general-purpose successor to the single-bit JK flip-flop, used wherever counters, toggle registers or small shifters are needed in the toolbox designs.

## Interface
- WIDTH, 8, number of JK cells; legal range 2..32
- RST_VAL, 0, value loaded into q on reset (WIDTH bits)
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- en  input  1  cycle enable; when low, q holds and tc=0
- mode  input  2  00 JK, 01 LOAD, 10 COUNT, 11 SHIFT
- j  input  WIDTH  per-bit J, used in JK mode
- k  input  WIDTH  per-bit K, used in JK mode
- d  input  WIDTH  parallel data, used in LOAD mode
- dir  input  1  COUNT direction (1 up, 0 down) and SHIFT direction (1 left, 0 right)
- sin  input  1  serial input for SHIFT mode
- q  output  WIDTH  register state
- tc  output  1  registered terminal-count pulse
- sout  output  1  serial output: q[WIDTH-1] when dir=1, q[0] when dir=0

## Operation
- Priority order: rst > en > mode.
- **rst=1:** q=RST_VAL, tc=0, regardless of en and mode.
- **en=0:** q holds, tc=0.
- **JK mode, per bit i:**
  - j=0, k=0: hold.
  - j=0, k=1: clear.
  - j=1, k=0: set.
  - j=1, k=1: toggle.
  - Bits are independent.
- **LOAD mode:** q=d.
- **COUNT mode:**
  - Implemented as per-bit JK cells with J=K=T[i].
  - Up: T[0]=1, and T[i]=&q[i-1:0].
  - Down: T[0]=1, and T[i]=&~q[i-1:0].
  - Arithmetic is modulo 2^WIDTH: up from all-ones wraps to 0, down from 0 wraps to all-ones.
  - tc=1 in the cycle after the wrapping edge (registered). Otherwise tc=0.
- **SHIFT mode:**
  - dir=1: q={q[WIDTH-2:0], sin}.
  - dir=0: q={sin, q[WIDTH-1:1]}.
  - tc=0.
- tc is only ever asserted by a COUNT-mode wrap. Every other mode drives tc=0.
- sout is a combinational mux from registered q. It follows dir immediately with no clock delay.
- mode and dir may change on any cycle. The new mode takes effect on the next rising edge with no state carried over, other than q itself.

## Timing
- All state updates on the rising edge of clk. Latency from input to q is 1 cycle.
- tc is registered and aligned with the q value that wrapped: it is high in the same cycle q shows 0 (up) or all-ones (down).
- tc lasts exactly one cycle per wrap. A counter held in COUNT mode at WIDTH=2 produces tc every 4th cycle.
- **Reset mid-count:** q=RST_VAL on the next edge. A tc already high clears in that same edge.
- **Reset released:** the first enabled edge after rst falls operates normally from RST_VAL.
- **en deasserted mid-count:** q freezes and tc drops after one cycle. On re-enable, counting resumes from the frozen value.
- **Direction reversal at a boundary:** switching dir while q=0 in COUNT mode, with down on the next edge, gives q=all-ones and tc=1.

## Structure
- Shared package jk_pkg holds:
  - the mode enumeration (MODE_JK, MODE_LOAD, MODE_COUNT, MODE_SHIFT) as a 2-bit typedef;
  - the direction constants DIR_UP/LEFT=1 and DIR_DOWN/RIGHT=0.
- Sub-module jk_cell: single-bit JK flip-flop with synchronous active-high reset, a reset value input, and an enable input.
- The top level instantiates WIDTH jk_cells through a generate loop.
- Mode logic computes each cell's effective J/K inputs:
  - LOAD: J=d[i], K=~d[i].
  - SHIFT: J=neighbour bit, K=~neighbour bit.
  - COUNT: J=K=T[i].
- tc and sout live in the top level.

## Test plan
- **Reset priority:** WIDTH=8, RST_VAL=8'hA5, with rst=1, en=1, mode=LOAD, d=8'hFF → q=8'hA5, tc=0.
- **JK mode:** starting from q=8'h0F, apply j=8'hF0, k=8'h3C → q=8'hF3 after one edge. Then j=k=8'hFF → q=8'h0C.
- **Count up with wrap:**
  - LOAD 8'hFD, then COUNT dir=1 for 4 edges → q sequence FE, FF, 00, 01.
  - tc=1 only in the cycle where q=00.
- **Count down with pause:**
  - From q=8'h01, COUNT dir=0 gives q=00 then FF, with tc=1 at FF.
  - Drop en for 3 cycles → q stays FF, tc=0.
  - Re-enable → q=FE.
- **Shift:**
  - From q=8'h81, dir=1, sin=0 → q=8'h02 and sout=q[7]=0.
  - Then dir=0, sin=1 → q=8'h81.
- **Mid-count reset:** count up from 8'hFE, assert rst on the edge where q would wrap → q=RST_VAL, tc=0 throughout.
